// File: rtl/dmem_responder.sv
// Data-memory responder: RV32 byte/half/word loads and stores into an on-chip word array.
// Latency: a request launched after edge N is taken at edge N+1; resp_valid is high after edge N+WAIT_CYCLES+2.
// Backpressure: req_ready is high only in IDLE, so one transaction at a time; build option DMEM_ALIGN_CHECK_EN adds misalignment faults.
module dmem_responder #(
  parameter int          ADDR_WIDTH  = 15,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
  localparam logic [32:0] SPAN      = 33'd4 << ADDR_WIDTH;

  state_t state, state_nxt;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic [3:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic [2:0]  lat_op;

  logic [31:0]           off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic [1:0]            eff_lane;
  logic                  op_legal;
  logic                  misalign;
  logic                  fault;
  logic [31:0]           rd_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           load_data;
  logic [3:0]            wr_be;
  logic [31:0]           wr_lanes;
  logic                  wr_en;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (wait_cnt == WAIT_LAST) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
  end

  // Capture the request at acceptance and run the wait-state counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_op    <= '0;
    end else if (state == S_IDLE && req_valid) begin
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_we    <= req_we;
      lat_op    <= req_op;
      wait_cnt  <= (WAIT_CYCLES > 0) ? 4'd1 : 4'd0;
    end else if (state == S_WAIT) begin
      wait_cnt  <= (wait_cnt == WAIT_LAST) ? 4'd0 : wait_cnt + 4'd1;
    end
  end

  // Address decode and fault classification on the captured request.
  always_comb begin
    off      = lat_addr - BASE_ADDR;
    in_range = ({1'b0, off} < SPAN);
    idx      = off[ADDR_WIDTH+1:2];
    lane     = off[1:0];
    case (lat_op)
      3'b000, 3'b001, 3'b010: op_legal = 1'b1;
      3'b100, 3'b101:         op_legal = !lat_we;
      default:                op_legal = 1'b0;
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    misalign = ((lat_op[1:0] == 2'b01) && lane[0]) || ((lat_op[1:0] == 2'b10) && (lane != 2'b00));
`else
    misalign = 1'b0;
`endif
    fault = !in_range || !op_legal || misalign;
    // Halves ignore lane[0] and words ignore both lane bits when alignment is not enforced.
    case (lat_op[1:0])
      2'b00:   eff_lane = lane;
      2'b01:   eff_lane = {lane[1], 1'b0};
      default: eff_lane = 2'b00;
    endcase
  end

  // Load lane extraction and extension; store byte enables and lane replication.
  always_comb begin
    rd_word = mem[idx];
    ld_byte = rd_word[{eff_lane, 3'b000} +: 8];
    ld_half = rd_word[{eff_lane[1], 4'b0000} +: 16];
    case (lat_op[1:0])
      2'b00:   load_data = lat_op[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_data = lat_op[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = rd_word;
    endcase
    case (lat_op[1:0])
      2'b00: begin
        wr_be    = 4'b0001 << eff_lane;
        wr_lanes = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        wr_be    = eff_lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{lat_wdata[15:0]}};
      end
      default: begin
        wr_be    = 4'b1111;
        wr_lanes = lat_wdata;
      end
    endcase
    wr_en = (state == S_ACCESS) && lat_we && !fault;
  end

  // Array write commits on the edge leaving ACCESS; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  // Response data/error registered on entry to RESP and held until the next one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (state == S_ACCESS) begin
      resp_rdata <= (fault || lat_we) ? 32'd0 : load_data;
      resp_err   <= fault;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int W = 1;
  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010, OP_BU = 3'b100, OP_HU = 3'b101;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.ADDR_WIDTH(15), .BASE_ADDR(32'h0010_0000), .WAIT_CYCLES(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_op     (req_op),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && resp_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%08h, expected no response", resp_rdata);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        chk({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  // The request is launched just after edge N and taken at edge N+1;
  // its response must be visible in the cycle after edge N+W+2.
  task automatic do_req(input string name, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd_exp, input logic err_exp, input bit push);
    int n;
    n = 0;
    @(posedge clock); #1;
    while (!req_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout: got req_ready=0 for 50 cycles, expected 1", name);
    end else begin
      req_valid = 1'b1;
      req_we    = we;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      if (push) sb_q.push_back('{rd_exp, err_exp, cyc + W + 2, name});
      @(posedge clock); #1;
      // Scramble inputs: the responder must use only the captured copy.
      req_valid = 1'b0;
      req_we    = ~we;
      req_op    = 3'b111;
      req_addr  = 32'hFFFF_FFF0;
      req_wdata = $urandom;
      chk({name, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic ld(input string name, input logic [2:0] op, input logic [31:0] addr,
                    input logic [31:0] rd_exp, input logic err_exp);
    do_req(name, 1'b0, op, addr, 32'hA5A5_A5A5, rd_exp, err_exp, 1'b1);
    drain();
  endtask

  task automatic st(input string name, input logic [2:0] op, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic err_exp);
    do_req(name, 1'b1, op, addr, wdata, 32'd0, err_exp, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_op    = 3'b000;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    #2;
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_err", {31'd0, resp_err}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Word store/load and byte extraction from the same word.
    st("sw_base", OP_W, 32'h0010_0000, 32'hDEAD_BEEF, 1'b0);
    ld("lw_base", OP_W, 32'h0010_0000, 32'hDEAD_BEEF, 1'b0);
    ld("lb_lane3", OP_B, 32'h0010_0003, 32'hFFFF_FFDE, 1'b0);
    ld("lbu_lane2", OP_BU, 32'h0010_0002, 32'h0000_00AD, 1'b0);

    // Byte store touches only its lane; only the low byte of wdata is used.
    st("sw_w1", OP_W, 32'h0010_0004, 32'h1122_3344, 1'b0);
    st("sb_lane1", OP_B, 32'h0010_0005, 32'h5A5A_5AAB, 1'b0);
    ld("lb_lane1", OP_B, 32'h0010_0005, 32'hFFFF_FFAB, 1'b0);
    ld("lbu_lane1", OP_BU, 32'h0010_0005, 32'h0000_00AB, 1'b0);
    ld("lw_after_sb", OP_W, 32'h0010_0004, 32'h1122_AB44, 1'b0);

    // Half store/load, both halves, sign and zero extension.
    st("sw_w2", OP_W, 32'h0010_0008, 32'hCAFE_F00D, 1'b0);
    st("sh_low", OP_H, 32'h0010_0008, 32'h1234_8001, 1'b0);
    ld("lh_low", OP_H, 32'h0010_0008, 32'hFFFF_8001, 1'b0);
    ld("lhu_low", OP_HU, 32'h0010_0008, 32'h0000_8001, 1'b0);
    ld("lh_high", OP_H, 32'h0010_000A, 32'hFFFF_CAFE, 1'b0);
    ld("lhu_high", OP_HU, 32'h0010_000A, 32'h0000_CAFE, 1'b0);
    ld("lw_after_sh", OP_W, 32'h0010_0008, 32'hCAFE_8001, 1'b0);

    // Range boundaries: last word works; just below base and just past the end fault.
    st("sw_last", OP_W, 32'h0011_FFFC, 32'h55AA_55AA, 1'b0);
    ld("lw_last", OP_W, 32'h0011_FFFC, 32'h55AA_55AA, 1'b0);
    ld("lw_below", OP_W, 32'h000F_FFFC, 32'd0, 1'b1);
    ld("lw_past", OP_W, 32'h0012_0000, 32'd0, 1'b1);
    st("sw_below", OP_W, 32'h000F_FFFC, 32'hFFFF_FFFF, 1'b1);
    st("sw_past", OP_W, 32'h0012_0000, 32'h0000_0000, 1'b1);
    ld("lw_last_kept", OP_W, 32'h0011_FFFC, 32'h55AA_55AA, 1'b0);
    ld("lw_base_kept", OP_W, 32'h0010_0000, 32'hDEAD_BEEF, 1'b0);

    // Illegal operation codes fault without touching the array.
    ld("ld_op011", 3'b011, 32'h0010_0000, 32'd0, 1'b1);
    ld("ld_op110", 3'b110, 32'h0010_0000, 32'd0, 1'b1);
    st("st_op100", OP_BU, 32'h0010_0000, 32'h0000_0000, 1'b1);
    st("st_op101", OP_HU, 32'h0010_0000, 32'h0000_0000, 1'b1);
    ld("lw_base_kept2", OP_W, 32'h0010_0000, 32'hDEAD_BEEF, 1'b0);

    // Back-to-back requests at the minimum spacing.
    do_req("b2b_0", 1'b0, OP_W, 32'h0010_0004, 32'd0, 32'h1122_AB44, 1'b0, 1'b1);
    do_req("b2b_1", 1'b0, OP_W, 32'h0010_0008, 32'd0, 32'hCAFE_8001, 1'b0, 1'b1);
    drain();

    // Reset while the store waits: no response, no write.
    st("sw_old", OP_W, 32'h0010_0010, 32'h0BAD_F00D, 1'b0);
    do_req("sw_abort", 1'b1, OP_W, 32'h0010_0010, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    ld("lw_after_abort", OP_W, 32'h0010_0010, 32'h0BAD_F00D, 1'b0);

    // Misaligned accesses.
`ifdef DMEM_ALIGN_CHECK_EN
    ld("lw_misalign", OP_W, 32'h0010_0002, 32'd0, 1'b1);
    ld("lh_misalign", OP_H, 32'h0010_0001, 32'd0, 1'b1);
    st("sh_misalign", OP_H, 32'h0010_0001, 32'h0000_FFFF, 1'b1);
    ld("lw_base_kept3", OP_W, 32'h0010_0000, 32'hDEAD_BEEF, 1'b0);
`else
    ld("lw_misalign", OP_W, 32'h0010_0002, 32'hDEAD_BEEF, 1'b0);
    ld("lh_misalign", OP_H, 32'h0010_0001, 32'hFFFF_BEEF, 1'b0);
    ld("lhu_misalign", OP_HU, 32'h0010_0003, 32'h0000_DEAD, 1'b0);
    st("sw_misalign", OP_W, 32'h0010_0013, 32'h7777_8888, 1'b0);
    ld("lw_after_sw_mis", OP_W, 32'h0010_0010, 32'h7777_8888, 1'b0);
`endif

    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
